// File: rtl/status_flags.sv
// 6502 processor status register (P): ALU/data/BIT/immediate flag updates,
// interrupt-entry I forcing, PHP/BRK push value and the lagged IRQ mask.
module status_flags #(
    parameter logic [7:0] RESET_P = 8'h24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       update_en,
    input  logic [1:0] src_sel,
    input  logic [7:0] flag_we,
    input  logic       alu_carry,
    input  logic       alu_overflow,
    input  logic       alu_zero,
    input  logic       alu_sign,
    input  logic [7:0] data_in,
    input  logic       imm_val,
    input  logic       int_entry,
    input  logic       instr_done,
    input  logic       push_brk,
    output logic [7:0] p_out,
    output logic [7:0] push_val,
    output logic       carry_flag,
    output logic       irq_mask
);

    typedef enum logic [1:0] {
        SRC_ALU  = 2'd0,
        SRC_DATA = 2'd1,
        SRC_BIT  = 2'd2,
        SRC_IMM  = 2'd3
    } src_e;

    localparam int BIT_C = 0;
    localparam int BIT_Z = 1;
    localparam int BIT_I = 2;
    localparam int BIT_D = 3;
    localparam int BIT_V = 6;
    localparam int BIT_N = 7;

    // Bits 5 and 4 have no storage, so they are never writable.
    localparam logic [7:0] STORED_MASK = 8'b1100_1111;

    logic flag_n, flag_v, flag_d, flag_i, flag_z, flag_c;
    logic next_n, next_v, next_d, next_i, next_z, next_c;
    logic irq_mask_q;

    src_e       src;
    logic [7:0] cand;
    logic [7:0] allowed;
    logic [7:0] eff_we;

    assign src = src_e'(src_sel);

    // Candidate value per P position plus the set of bits each source may touch.
    always_comb begin
        cand    = 8'h00;
        allowed = 8'h00;
        case (src)
            SRC_ALU: begin
                cand[BIT_N] = alu_sign;
                cand[BIT_V] = alu_overflow;
                cand[BIT_Z] = alu_zero;
                cand[BIT_C] = alu_carry;
                allowed     = 8'b1100_0011;
            end
            SRC_DATA: begin
                cand    = data_in;
                allowed = STORED_MASK;
            end
            SRC_BIT: begin
                cand[BIT_N] = data_in[7];
                cand[BIT_V] = data_in[6];
                cand[BIT_Z] = alu_zero;
                allowed     = 8'b1100_0010;
            end
            SRC_IMM: begin
                cand    = {8{imm_val}};
                allowed = STORED_MASK;
            end
            default: begin
                cand    = 8'h00;
                allowed = 8'h00;
            end
        endcase
    end

    assign eff_we = update_en ? (flag_we & allowed & STORED_MASK) : 8'h00;

    always_comb begin
        next_n = eff_we[BIT_N] ? cand[BIT_N] : flag_n;
        next_v = eff_we[BIT_V] ? cand[BIT_V] : flag_v;
        next_d = eff_we[BIT_D] ? cand[BIT_D] : flag_d;
        next_z = eff_we[BIT_Z] ? cand[BIT_Z] : flag_z;
        next_c = eff_we[BIT_C] ? cand[BIT_C] : flag_c;
        next_i = eff_we[BIT_I] ? cand[BIT_I] : flag_i;
        if (int_entry) begin
            next_i = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flag_n <= RESET_P[BIT_N];
            flag_v <= RESET_P[BIT_V];
            flag_d <= RESET_P[BIT_D];
            flag_i <= RESET_P[BIT_I];
            flag_z <= RESET_P[BIT_Z];
            flag_c <= RESET_P[BIT_C];
        end else begin
            flag_n <= next_n;
            flag_v <= next_v;
            flag_d <= next_d;
            flag_i <= next_i;
            flag_z <= next_z;
            flag_c <= next_c;
        end
    end

    // The IRQ poll sees the I value held at the last instruction boundary,
    // so CLI/SEI/PLP take effect one instruction late; interrupt entry masks at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_mask_q <= RESET_P[BIT_I];
        end else if (int_entry) begin
            irq_mask_q <= 1'b1;
        end else if (instr_done) begin
            irq_mask_q <= flag_i;
        end
    end

    assign p_out      = {flag_n, flag_v, 1'b1, 1'b0, flag_d, flag_i, flag_z, flag_c};
    assign push_val   = {flag_n, flag_v, 1'b1, push_brk, flag_d, flag_i, flag_z, flag_c};
    assign carry_flag = flag_c;
    assign irq_mask   = irq_mask_q;

endmodule

// File: tb/tb_status_flags.sv
// Directed self-checking bench for status_flags using hand-computed P values.
module tb_status_flags;

    logic       clk = 1'b0;
    logic       reset;
    logic       update_en;
    logic [1:0] src_sel;
    logic [7:0] flag_we;
    logic       alu_carry;
    logic       alu_overflow;
    logic       alu_zero;
    logic       alu_sign;
    logic [7:0] data_in;
    logic       imm_val;
    logic       int_entry;
    logic       instr_done;
    logic       push_brk;
    logic [7:0] p_out;
    logic [7:0] push_val;
    logic       carry_flag;
    logic       irq_mask;

    int total = 0;
    int bad   = 0;

    localparam logic [1:0] ALU  = 2'd0;
    localparam logic [1:0] DATA = 2'd1;
    localparam logic [1:0] BITS = 2'd2;
    localparam logic [1:0] IMM  = 2'd3;

    status_flags #(.RESET_P(8'h24)) dut (
        .clk          (clk),
        .reset        (reset),
        .update_en    (update_en),
        .src_sel      (src_sel),
        .flag_we      (flag_we),
        .alu_carry    (alu_carry),
        .alu_overflow (alu_overflow),
        .alu_zero     (alu_zero),
        .alu_sign     (alu_sign),
        .data_in      (data_in),
        .imm_val      (imm_val),
        .int_entry    (int_entry),
        .instr_done   (instr_done),
        .push_brk     (push_brk),
        .p_out        (p_out),
        .push_val     (push_val),
        .carry_flag   (carry_flag),
        .irq_mask     (irq_mask)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%02h expected=%02h", tag, got, exp);
        end
    endtask

    // alu = {sign, overflow, zero, carry}; one clock, outputs sampled 1 time unit after the edge
    task automatic applyStimulus(input logic rst, input logic upd, input logic [1:0] src,
                                 input logic [7:0] we, input logic [3:0] alu,
                                 input logic [7:0] data, input logic imm,
                                 input logic ie, input logic done);
        reset        = rst;
        update_en    = upd;
        src_sel      = src;
        flag_we      = we;
        alu_sign     = alu[3];
        alu_overflow = alu[2];
        alu_zero     = alu[1];
        alu_carry    = alu[0];
        data_in      = data;
        imm_val      = imm;
        int_entry    = ie;
        instr_done   = done;
        @(posedge clk);
        #1;
    endtask

    initial begin
        push_brk = 1'b0;
        #1;

        // Reset held two cycles against an all-zero PLP load
        applyStimulus(1, 1, DATA, 8'hFF, 4'h0, 8'h00, 0, 0, 0);
        applyStimulus(1, 1, DATA, 8'hFF, 4'h0, 8'h00, 0, 0, 0);
        checkOutput("reset_p", p_out, 8'h24);
        checkOutput("reset_irq", {7'd0, irq_mask}, 8'h01);
        checkOutput("reset_carry", {7'd0, carry_flag}, 8'h00);
        checkOutput("reset_push", push_val, 8'h24);

        // ALU capture of N,V,Z,C
        applyStimulus(0, 1, ALU, 8'hC3, 4'b1101, 8'h00, 0, 0, 0);
        checkOutput("alu_p", p_out, 8'hE5);
        checkOutput("alu_carry", {7'd0, carry_flag}, 8'h01);
        applyStimulus(0, 1, ALU, 8'h00, 4'b0010, 8'h00, 0, 0, 0);
        checkOutput("alu_hold_we0", p_out, 8'hE5);
        applyStimulus(0, 0, DATA, 8'hFF, 4'b0010, 8'h00, 0, 0, 0);
        checkOutput("hold_upd0", p_out, 8'hE5);

        // PLP of FF: bit4 reads 0, push inserts B
        applyStimulus(0, 1, DATA, 8'hFF, 4'h0, 8'hFF, 0, 0, 0);
        checkOutput("plp_p", p_out, 8'hEF);
        push_brk = 1'b1;
        #1;
        checkOutput("push_brk1", push_val, 8'hFF);
        push_brk = 1'b0;
        #1;
        checkOutput("push_brk0", push_val, 8'hEF);

        // BIT from reset state, then BIT with all enables leaves C,D,I
        applyStimulus(1, 0, ALU, 8'h00, 4'h0, 8'h00, 0, 0, 0);
        applyStimulus(0, 1, BITS, 8'hC2, 4'b0010, 8'hC0, 0, 0, 0);
        checkOutput("bit_p", p_out, 8'hE6);
        checkOutput("bit_carry", {7'd0, carry_flag}, 8'h00);
        applyStimulus(0, 1, BITS, 8'hFF, 4'b0001, 8'h0F, 0, 0, 0);
        checkOutput("bit_hold_cdi", p_out, 8'h24);

        // ALU with every enable set must not touch D or I
        applyStimulus(0, 1, ALU, 8'hFF, 4'b0011, 8'h00, 0, 0, 0);
        checkOutput("alu_no_di", p_out, 8'h27);

        // IMM set of everything, then CLI and its one-boundary lag
        applyStimulus(0, 1, IMM, 8'hFF, 4'h0, 8'h00, 1, 0, 0);
        checkOutput("imm_set", p_out, 8'hEF);
        applyStimulus(0, 1, IMM, 8'h04, 4'h0, 8'h00, 0, 0, 0);
        checkOutput("cli_p", p_out, 8'hEB);
        checkOutput("cli_irq_lag", {7'd0, irq_mask}, 8'h01);
        applyStimulus(0, 0, ALU, 8'h00, 4'h0, 8'h00, 0, 0, 1);
        checkOutput("cli_irq_done", {7'd0, irq_mask}, 8'h00);

        // SEI together with instr_done: irq_mask takes the old I
        applyStimulus(0, 1, IMM, 8'h04, 4'h0, 8'h00, 1, 0, 1);
        checkOutput("sei_p", p_out, 8'hEF);
        checkOutput("sei_irq_old", {7'd0, irq_mask}, 8'h00);
        applyStimulus(0, 0, ALU, 8'h00, 4'h0, 8'h00, 0, 0, 1);
        checkOutput("sei_irq_done", {7'd0, irq_mask}, 8'h01);

        // Clear I and C, then interrupt entry against an I clear and C set
        applyStimulus(0, 1, IMM, 8'h05, 4'h0, 8'h00, 0, 0, 0);
        applyStimulus(0, 0, ALU, 8'h00, 4'h0, 8'h00, 0, 0, 1);
        checkOutput("pre_int_p", p_out, 8'hEA);
        checkOutput("pre_int_irq", {7'd0, irq_mask}, 8'h00);
        applyStimulus(0, 1, DATA, 8'h05, 4'h0, 8'h01, 0, 1, 0);
        checkOutput("int_p", p_out, 8'hEF);
        checkOutput("int_irq", {7'd0, irq_mask}, 8'h01);
        checkOutput("int_carry", {7'd0, carry_flag}, 8'h01);
        applyStimulus(0, 1, IMM, 8'h04, 4'h0, 8'h00, 0, 1, 0);
        checkOutput("int_vs_imm_p", p_out, 8'hEF);

        // Reset with a pending cleared I and a boundary strobe
        applyStimulus(0, 1, IMM, 8'h04, 4'h0, 8'h00, 0, 0, 0);
        applyStimulus(1, 0, ALU, 8'h00, 4'h0, 8'h00, 0, 0, 1);
        checkOutput("rst_mid_p", p_out, 8'h24);
        checkOutput("rst_mid_irq", {7'd0, irq_mask}, 8'h01);
        applyStimulus(0, 0, ALU, 8'h00, 4'h0, 8'h00, 0, 0, 1);
        checkOutput("rst_mid_irq2", {7'd0, irq_mask}, 8'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
